// File: rtl/regfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
// Holds the clear-sequencer state encoding plus depth and packed-port slice helpers.
package regfile_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // Number of entries addressed by an addr_w-bit index.
    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // LSB of lane `port` inside a packed bus of `width`-bit lanes.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, hardwired-zero override and write bypass.
// Instantiated once per read port by regfile_multiport.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned DEPTH   = calc_depth(ADDR_W)
) (
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic is_zero_reg;
    logic bypass_hit;

    always_comb begin
        is_zero_reg = (ZERO_REG != 0) && (rd_addr == '0);
        // wr_valid already excludes the clear sweep, so bypass stays off while busy.
        bypass_hit  = (BYPASS != 0) && wr_valid && (rd_addr == wr_addr);
    end

    always_comb begin
        rd_data = mem[rd_addr];
        if (bypass_hit) begin
            rd_data = wr_data;
        end
        if (is_zero_reg) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write port, RD_PORTS read ports, optional zero register,
// optional write bypass and a sequenced bulk clear that stalls writes while sweeping.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic [DATA_W-1:0]            in_PC,
    input  logic [ADDR_W-1:0]            in_SC,
    input  logic                         in_RFL,
    input  logic [RD_PORTS*ADDR_W-1:0]   in_S,
    output logic [RD_PORTS*DATA_W-1:0]   out_P,
    input  logic                         in_clr,
    output logic                         out_busy,
    output logic                         out_wr_ready
);

    localparam int unsigned DEPTH = calc_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic                wr_ready_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    wr_dec;
    logic [DEPTH-1:0]    clr_dec;
    logic                wr_valid;
    logic                wr_en;

    // Write qualification: a load is only accepted while the sweep is idle.
    always_comb begin
        wr_valid = in_RFL && wr_ready_q;
        wr_en    = wr_valid && !((ZERO_REG != 0) && (in_SC == '0));
    end

    always_comb begin
        wr_dec  = '0;
        clr_dec = '0;
        if (wr_en) begin
            wr_dec[in_SC] = 1'b1;
        end
        if (state_q == StClear) begin
            clr_dec[cnt_q] = 1'b1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_dec[i]) begin
                    mem_q[i] <= '0;
                end else if (wr_dec[i]) begin
                    mem_q[i] <= in_PC;
                end
            end
        end
    end

    // Clear sequencer; busy and ready are registered alongside the state so no
    // combinational path runs from in_clr to the outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_clr) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                StClear: begin
                    if (cnt_q == LastAddr) begin
                        state_q    <= StIdle;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cnt_q      <= '0;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_busy     = busy_q;
    assign out_wr_ready = wr_ready_q;

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd_port
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .mem      (mem_q),
            .rd_addr  (in_S[port_lsb(k, ADDR_W) +: ADDR_W]),
            .wr_valid (wr_valid),
            .wr_addr  (in_SC),
            .wr_data  (in_PC),
            .rd_data  (out_P[port_lsb(k, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised, model-checked bench for regfile_multiport in two configurations:
// default (32x32, 2 ports, zero reg, bypass) and small (8x16, 4 ports, no zero reg, no bypass).
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: defaults.
    logic [31:0] pc0;
    logic [4:0]  sc0;
    logic        rfl0, clr0;
    logic [9:0]  s0;
    logic [63:0] p0;
    logic        busy0, rdy0;

    // Instance 1: small, no zero register, no bypass.
    logic [15:0] pc1;
    logic [2:0]  sc1;
    logic        rfl1, clr1;
    logic [11:0] s1;
    logic [63:0] p1;
    logic        busy1, rdy1;

    regfile_multiport u_dut0 (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_PC        (pc0),
        .in_SC        (sc0),
        .in_RFL       (rfl0),
        .in_S         (s0),
        .out_P        (p0),
        .in_clr       (clr0),
        .out_busy     (busy0),
        .out_wr_ready (rdy0)
    );

    regfile_multiport #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .RD_PORTS (4),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) u_dut1 (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_PC        (pc1),
        .in_SC        (sc1),
        .in_RFL       (rfl1),
        .in_S         (s1),
        .out_P        (p1),
        .in_clr       (clr1),
        .out_busy     (busy1),
        .out_wr_ready (rdy1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain array contents plus the index the sweep will clear next (-1 = idle).
    logic [31:0] mmem [2][32];
    int          msweep [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic bit zero_of(input int i);
        return i == 0;
    endfunction

    function automatic bit bypass_of(input int i);
        return i == 0;
    endfunction

    task automatic model_edge(input int i, input int unsigned wa, input logic [31:0] wd,
                              input bit rfl, input bit clr);
        if (msweep[i] >= 0) begin
            mmem[i][msweep[i]] = '0;
            msweep[i]++;
            if (msweep[i] == depth_of(i)) msweep[i] = -1;
        end else begin
            if (rfl && !(zero_of(i) && wa == 0)) mmem[i][wa] = wd;
            if (clr) msweep[i] = 0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i, input int unsigned a,
                                           input int unsigned wa, input logic [31:0] wd,
                                           input bit rfl);
        if (zero_of(i) && a == 0) return '0;
        if (bypass_of(i) && rfl && msweep[i] < 0 && a == wa) return wd;
        return mmem[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) mmem[i][j] = '0;
            msweep[i] = -1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_edge(0, sc0, pc0, rfl0, clr0);
                model_edge(1, sc1, {16'h0, pc1}, rfl1, clr1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output of both instances, every cycle, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut0_port%0d", k), p0[k*32 +: 32],
                      exp_rd(0, s0[k*5 +: 5], sc0, pc0, rfl0));
            end
            check("dut0_busy", {31'b0, busy0}, 32'(msweep[0] >= 0));
            check("dut0_ready", {31'b0, rdy0}, 32'(msweep[0] < 0));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("dut1_port%0d", k), {16'h0, p1[k*16 +: 16]},
                      exp_rd(1, s1[k*3 +: 3], sc1, {16'h0, pc1}, rfl1));
            end
            check("dut1_busy", {31'b0, busy1}, 32'(msweep[1] >= 0));
            check("dut1_ready", {31'b0, rdy1}, 32'(msweep[1] < 0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        pc0 = '0; sc0 = '0; rfl0 = 1'b0; clr0 = 1'b0; s0 = '0;
        pc1 = '0; sc1 = '0; rfl1 = 1'b0; clr1 = 1'b0; s1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_ready", {31'b0, rdy0}, 32'd1);
        check("rst_port0", p0[31:0], 32'd0);
        check("rst_port1", p0[63:32], 32'd0);
        check("rst_busy_small", {31'b0, busy1}, 32'd0);

        // Basic write then read; port 1 on an unwritten register.
        sc0 = 5'd4; pc0 = 32'h4; rfl0 = 1'b1; s0 = {5'd3, 5'd4};
        tick();
        rfl0 = 1'b0;
        #1;
        check("wr4_read", p0[31:0], 32'h4);
        check("rd3_unwritten", p0[63:32], 32'h0);

        // Same-cycle visibility: bypass on instance 0, none on instance 1.
        sc0 = 5'd3; pc0 = 32'hFFFF_FFFF; rfl0 = 1'b1;
        sc1 = 3'd3; pc1 = 16'hFFFF; rfl1 = 1'b1; s1 = {3'd0, 3'd0, 3'd3, 3'd0};
        #1;
        check("bypass_before_edge", p0[63:32], 32'hFFFF_FFFF);
        check("nobypass_before_edge", {16'h0, p1[31:16]}, 32'h0);
        tick();
        rfl0 = 1'b0; rfl1 = 1'b0;
        #1;
        check("nobypass_after_edge", {16'h0, p1[31:16]}, 32'hFFFF);

        // Register 0: hardwired on instance 0, ordinary on instance 1.
        sc0 = 5'd0; pc0 = 32'hDEAD_BEEF; rfl0 = 1'b1; s0 = '0;
        sc1 = 3'd0; pc1 = 16'hBEEF; rfl1 = 1'b1; s1 = '0;
        #1;
        check("zero_reg_bypass_cycle", p0[31:0], 32'h0);
        tick();
        rfl0 = 1'b0; rfl1 = 1'b0;
        #1;
        check("zero_reg_after", p0[31:0], 32'h0);
        check("reg0_writable_small", {16'h0, p1[15:0]}, 32'hBEEF);

        // Random traffic on both instances, occasional clears.
        repeat (400) begin
            pc0 = $urandom; sc0 = 5'($urandom); rfl0 = 1'($urandom_range(0, 1));
            clr0 = ($urandom_range(0, 39) == 0); s0 = 10'($urandom);
            pc1 = 16'($urandom); sc1 = 3'($urandom); rfl1 = 1'($urandom_range(0, 1));
            clr1 = ($urandom_range(0, 39) == 0); s1 = 12'($urandom);
            tick();
        end
        clr0 = 1'b0; clr1 = 1'b0; rfl0 = 1'b0; rfl1 = 1'b0;
        for (int n = 0; n < 100 && (busy0 || busy1); n++) tick();
        check("idle_after_random", {30'b0, busy0, busy1}, 32'd0);

        // Fill every entry with its index, then sweep.
        for (int i = 0; i < 32; i++) begin
            sc0 = 5'(i); pc0 = 32'(i); rfl0 = 1'b1;
            tick();
        end
        rfl0 = 1'b0;
        check("model_fill_17", mmem[0][17], 32'd17);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        b = 0;
        while (busy0 && b < 100) begin
            b++;
            if (b == 11) begin
                s0 = {5'd20, 5'd5}; sc0 = 5'd20; pc0 = 32'h55; rfl0 = 1'b1;
                #1;
                check("mid_sweep_reg5", p0[31:0], 32'd0);
                check("mid_sweep_reg20", p0[63:32], 32'd20);
            end
            if (b == 12) begin
                rfl0 = 1'b0;
                #1;
                check("busy_write_dropped", p0[63:32], 32'd20);
            end
            tick();
        end
        rfl0 = 1'b0;
        check("sweep_len_32", b, 32'd32);
        for (int a = 0; a < 32; a++) begin
            s0[4:0] = 5'(a);
            #1;
            check($sformatf("post_clear_reg%0d", a), p0[31:0], 32'd0);
        end

        // Clear coincident with a write; a second clear mid-sweep is ignored.
        sc0 = 5'd7; pc0 = 32'h12; rfl0 = 1'b1; clr0 = 1'b1;
        tick();
        rfl0 = 1'b0; clr0 = 1'b0; s0 = {5'd0, 5'd7};
        #1;
        check("coincident_write_kept", p0[31:0], 32'h12);
        b = 0;
        while (busy0 && b < 100) begin
            b++;
            clr0 = (b == 5);
            if (b == 8) check("reg7_before_swept", p0[31:0], 32'h12);
            if (b == 9) check("reg7_swept", p0[31:0], 32'h0);
            tick();
        end
        clr0 = 1'b0;
        check("reclear_len_32", b, 32'd32);

        // Asynchronous reset between edges in the middle of a sweep.
        sc0 = 5'd30; pc0 = 32'h30; rfl0 = 1'b1;
        tick();
        rfl0 = 1'b0; clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        repeat (5) tick();
        s0 = {5'd30, 5'd9};
        #1;
        check("reg30_before_rst", p0[63:32], 32'h30);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy0}, 32'd0);
        check("async_rst_reg30", p0[63:32], 32'd0);
        tick();
        rst = 1'b0;
        sc0 = 5'd9; pc0 = 32'hABC; rfl0 = 1'b1;
        tick();
        rfl0 = 1'b0;
        #1;
        check("write_after_rst", p0[31:0], 32'hABC);

        // Small instance: four independent ports, 8-cycle sweep.
        for (int i = 0; i < 8; i++) begin
            sc1 = 3'(i); pc1 = 16'(16'h1111 * (i + 1)); rfl1 = 1'b1;
            tick();
        end
        rfl1 = 1'b0;
        s1 = {3'd0, 3'd3, 3'd6, 3'd1};
        #1;
        check("small_port0", {16'h0, p1[15:0]}, 32'h2222);
        check("small_port1", {16'h0, p1[31:16]}, 32'h7777);
        check("small_port2", {16'h0, p1[47:32]}, 32'h4444);
        check("small_port3", {16'h0, p1[63:48]}, 32'h1111);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        b = 0;
        while (busy1 && b < 100) begin
            b++;
            tick();
        end
        check("small_sweep_len_8", b, 32'd8);
        #1;
        check("small_port1_cleared", {16'h0, p1[31:16]}, 32'h0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
